// File: rtl/pd_pkg.sv
// Shared types and defaults for the "101" serial pattern detector.
package pd_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_1    = 2'd1,
      S_10   = 2'd2,
      S_101  = 2'd3
   } pd_state_t;

   localparam int HIST_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the divided clock, treated as a level in the fast domain.
module tick_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   output logic o_sample
);

   logic r_tick_d;

   // Resetting high keeps a tick already high at reset release from looking like an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_tick_d <= 1'b1;
      else       r_tick_d <= i_tick;
   end

   assign o_sample = i_tick & ~r_tick_d;

endmodule

// File: rtl/pattern_detector_101.sv
// Moore "101" detector sampled on divided-clock edges, with counter and bit history.
// Build option: define PD_OVERLAP_EN for overlapping detection ("10101" -> two hits).
module pattern_detector_101
   import pd_pkg::*;
#(
   parameter int HIST_W = HIST_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              tick_in,
   input  logic              bit_in,
   output logic              detect,
   output logic              det_pulse,
   output logic [CNT_W-1:0]  det_count,
   output logic [HIST_W-1:0] history,
   output logic [1:0]        state_out
);

   pd_state_t         r_state;
   pd_state_t         w_state_nxt;
   logic              w_sample;
   logic              r_detect;
   logic              r_pulse;
   logic [CNT_W-1:0]  r_count;
   logic [HIST_W-1:0] r_hist;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   tick_edge_detect u_tick_edge (
      .i_clk    (clk_in),
      .i_rst    (reset),
      .i_tick   (tick_in),
      .o_sample (w_sample)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: w_state_nxt = bit_in ? S_1   : S_IDLE;
         S_1:    w_state_nxt = bit_in ? S_1   : S_10;
         S_10:   w_state_nxt = bit_in ? S_101 : S_IDLE;
`ifdef PD_OVERLAP_EN
         S_101:  w_state_nxt = bit_in ? S_1   : S_10;
`else
         S_101:  w_state_nxt = bit_in ? S_1   : S_IDLE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Everything advances only on a sample; between samples the outputs hold and the pulse drops.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_detect <= 1'b0;
         r_pulse  <= 1'b0;
         r_count  <= '0;
         r_hist   <= '0;
      end else if (w_sample) begin
         r_state  <= w_state_nxt;
         r_detect <= (w_state_nxt == S_101);
         r_pulse  <= (w_state_nxt == S_101) && (r_state != S_101);
         r_hist   <= {r_hist[HIST_W-2:0], bit_in};
         if ((w_state_nxt == S_101) && (r_state != S_101))
            r_count <= sat_inc(r_count);
      end else begin
         r_pulse  <= 1'b0;
      end
   end

   assign detect    = r_detect;
   assign det_pulse = r_pulse;
   assign det_count = r_count;
   assign history   = r_hist;
   assign state_out = r_state;

endmodule

// File: tb/tb_pattern_detector_101.sv
// Scoreboard bench for pattern_detector_101: default instance plus a CNT_W=2 instance on shared stimulus.
module tb_pattern_detector_101;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       tick_in;
   logic       bit_in;
   logic       detect, det_pulse;
   logic [7:0] det_count, history;
   logic [1:0] state_out;
   logic       detect2, det_pulse2;
   logic [1:0] det_count2;
   logic [7:0] history2;
   logic [1:0] state_out2;

   always #5 clk_in = ~clk_in;

   pattern_detector_101 dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .tick_in   (tick_in),
      .bit_in    (bit_in),
      .detect    (detect),
      .det_pulse (det_pulse),
      .det_count (det_count),
      .history   (history),
      .state_out (state_out)
   );

   pattern_detector_101 #(.HIST_W(8), .CNT_W(2)) dut_sat (
      .clk_in    (clk_in),
      .reset     (reset),
      .tick_in   (tick_in),
      .bit_in    (bit_in),
      .detect    (detect2),
      .det_pulse (det_pulse2),
      .det_count (det_count2),
      .history   (history2),
      .state_out (state_out2)
   );

   typedef struct {
      logic [1:0] st;
      logic       pulse;
      logic [7:0] c1;
      logic [1:0] c2;
      logic [7:0] h;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   p2_cnt = 0;

   logic [7:0] m_hist;
   logic [7:0] m_cnt1;
   logic [1:0] m_cnt2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge clk_in) if (det_pulse2 === 1'b1) p2_cnt++;

   // Monitor: detects sample edges independently and checks the cycle after.
   initial begin
      logic tprev;
      logic smp;
      logic chk_low;
      exp_t e;
      tprev   = 1'b1;
      chk_low = 1'b0;
      forever begin
         @(posedge clk_in);
         smp   = (reset === 1'b0) && (tick_in === 1'b1) && (tprev === 1'b0);
         tprev = (reset === 1'b1) ? 1'b1 : tick_in;
         @(negedge clk_in);
         if (chk_low) begin
            chk("pulse_low", {30'd0, det_pulse, det_pulse2}, 32'd0);
            chk_low = 1'b0;
         end
         if (smp) begin
            if (q.size() == 0) begin
               chk("unexpected_sample", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("state_out", {30'd0, state_out}, {30'd0, e.st});
               chk("detect", {31'd0, detect}, {31'd0, (e.st == 2'd3)});
               chk("det_pulse", {31'd0, det_pulse}, {31'd0, e.pulse});
               chk("det_count", {24'd0, det_count}, {24'd0, e.c1});
               chk("history", {24'd0, history}, {24'd0, e.h});
               chk("sat_count", {30'd0, det_count2}, {30'd0, e.c2});
               chk("sat_pulse", {31'd0, det_pulse2}, {31'd0, e.pulse});
               chk_low = e.pulse;
            end
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk_in);
      reset = 1'b1;
      repeat (n) @(negedge clk_in);
      reset  = 1'b0;
      m_hist = '0;
      m_cnt1 = '0;
      m_cnt2 = '0;
   endtask

   // One slow period: tick rises with bit_in, high 5 cycles, low 5 cycles.
   task automatic do_sample(input logic b, input logic [1:0] st, input bit toggle);
      exp_t e;
      @(negedge clk_in);
      bit_in  = b;
      tick_in = 1'b1;
      m_hist  = {m_hist[6:0], b};
      if (st == 2'd3) begin
         if (m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
         if (m_cnt2 != 2'h3)  m_cnt2 = m_cnt2 + 2'd1;
      end
      e.st = st; e.pulse = (st == 2'd3); e.c1 = m_cnt1; e.c2 = m_cnt2; e.h = m_hist;
      q.push_back(e);
      repeat (4) begin
         @(negedge clk_in);
         if (toggle) bit_in = ~bit_in;
      end
      @(negedge clk_in);
      tick_in = 1'b0;
      repeat (4) begin
         @(negedge clk_in);
         if (toggle) bit_in = ~bit_in;
      end
   endtask

   logic [1:0] st5[5];
   int         p_base;

   initial begin
      reset   = 1'b1;
      tick_in = 1'b1;
      bit_in  = 1'b0;
      m_hist  = '0;
      m_cnt1  = '0;
      m_cnt2  = '0;

      // Reset with tick held high, released while still high: no sample.
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_detect", {31'd0, detect}, 32'd0);
      chk("rst_pulse", {31'd0, det_pulse}, 32'd0);
      chk("rst_count", {24'd0, det_count}, 32'd0);
      chk("rst_history", {24'd0, history}, 32'd0);
      chk("rst_state", {30'd0, state_out}, 32'd0);
      tick_in = 1'b0;
      repeat (4) @(negedge clk_in);

      // "10101"
`ifdef PD_OVERLAP_EN
      st5 = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
`else
      st5 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
      do_sample(1'b1, st5[0], 1'b0);
      do_sample(1'b0, st5[1], 1'b0);
      do_sample(1'b1, st5[2], 1'b0);
      do_sample(1'b0, st5[3], 1'b0);
      do_sample(1'b1, st5[4], 1'b0);
      chk("seq_history", {24'd0, history}, 32'h15);
`ifdef PD_OVERLAP_EN
      chk("seq_count", {24'd0, det_count}, 32'd2);
      chk("seq_state", {30'd0, state_out}, 32'd3);
`else
      chk("seq_count", {24'd0, det_count}, 32'd1);
      chk("seq_state", {30'd0, state_out}, 32'd1);
`endif

      // "101" x5: same states in both builds; narrow counter saturates at 3.
      do_reset(2);
      p_base = p2_cnt;
      for (int i = 0; i < 5; i++) begin
         do_sample(1'b1, (i == 0) ? 2'd1 : 2'd1, 1'b0);
         do_sample(1'b0, 2'd2, 1'b0);
         do_sample(1'b1, 2'd3, 1'b0);
      end
      chk("sat_final", {30'd0, det_count2}, 32'd3);
      chk("wide_final", {24'd0, det_count}, 32'd5);
      chk("sat_pulses", p2_cnt - p_base, 32'd5);
      chk("rep_history", {24'd0, history}, 32'h6D);

      // Partial "10" discarded by a one-cycle reset.
      do_reset(2);
      do_sample(1'b1, 2'd1, 1'b0);
      do_sample(1'b0, 2'd2, 1'b0);
      do_reset(1);
      @(negedge clk_in);
      chk("mid_rst_state", {30'd0, state_out}, 32'd0);
      chk("mid_rst_history", {24'd0, history}, 32'd0);
      do_sample(1'b1, 2'd1, 1'b0);
      chk("post_rst_state", {30'd0, state_out}, 32'd1);
      chk("post_rst_detect", {31'd0, detect}, 32'd0);
      chk("post_rst_count", {24'd0, det_count}, 32'd0);
      chk("post_rst_history", {24'd0, history}, 32'h01);

      // bit_in toggling between ticks; only tick-edge values 1,1,0,1 count.
      do_reset(2);
      do_sample(1'b1, 2'd1, 1'b1);
      do_sample(1'b1, 2'd1, 1'b1);
      do_sample(1'b0, 2'd2, 1'b1);
      do_sample(1'b1, 2'd3, 1'b1);
      chk("tog_history", {24'd0, history}, 32'h0D);
      chk("tog_count", {24'd0, det_count}, 32'd1);
      chk("tog_detect_held", {31'd0, detect}, 32'd1);

      repeat (5) @(negedge clk_in);
      chk("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
